// File: rtl/lattice_result_collector.sv
// Lattice result collector: rebuilds the winning nonce from the slice counter and
// partition index, tags it with the block id, buffers hits in a small FIFO and
// presents them on a valid/ready port. Also flags nonce-space exhaustion.
// Optional build macro: STALE_FLUSH_EN (a new block discards queued hits).
//
// state     | meaning
// IDLE      | waiting for the first new-block result after reset
// SCAN      | counting slices of the current block, hits accepted
// EXHAUSTED | nonce space of the current block used up, waiting for a new block
module lattice_result_collector #(
   parameter int LOG2_NUM_CORES = 1,
   parameter int NONCE_BITS     = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int BLOCK_ID_BITS  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_i,
   input  logic                      new_block_i,
   input  logic                      success_i,
   input  logic [LOG2_NUM_CORES-1:0] partition_i,
   output logic                      res_valid_o,
   input  logic                      res_ready_i,
   output logic [NONCE_BITS-1:0]     res_nonce_o,
   output logic [BLOCK_ID_BITS-1:0]  res_block_o,
   output logic                      exhausted_o,
   output logic                      overflow_o
);

   localparam int CNT_W   = NONCE_BITS - LOG2_NUM_CORES;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = NONCE_BITS + BLOCK_ID_BITS;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

`ifdef STALE_FLUSH_EN
   localparam logic FLUSH_EN = 1'b1;
`else
   localparam logic FLUSH_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SCAN, EXHAUSTED} state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [BLOCK_ID_BITS-1:0]   blk_q, blk_d;
   logic                       exh_d;
   logic                       new_blk, accept, push_req;
   logic [NONCE_BITS-1:0]      nonce;
   logic [BLOCK_ID_BITS-1:0]   tag;

   logic [ENTRY_W-1:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]           wr_q, wr_d, rd_q, rd_d;
   logic [PTR_W:0]             fill_q, fill_d, base;
   logic                       pop, flush, do_push, drop;
   logic [ENTRY_W-1:0]         wdata, head_d;

   // Next-state, slice counter, block id and nonce reconstruction for this cycle
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      blk_d    = blk_q;
      exh_d    = exhausted_o;
      new_blk  = valid_i & new_block_i;
      accept   = new_blk | (valid_i & (state_q == SCAN));
      nonce    = {cnt_q, partition_i};
      tag      = blk_q;
      if (new_blk) begin
         // A new block restarts the slice count at 0 for this very result
         state_d = SCAN;
         cnt_d   = CNT_W'(1);
         blk_d   = blk_q + 1'b1;
         exh_d   = 1'b0;
         nonce   = {{CNT_W{1'b0}}, partition_i};
         tag     = blk_q + 1'b1;
      end else begin
         case (state_q)
            SCAN: begin
               if (valid_i) begin
                  cnt_d = cnt_q + 1'b1;
                  if (&cnt_q) begin
                     state_d = EXHAUSTED;
                     exh_d   = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
      push_req = accept & success_i;
   end

   // FIFO bookkeeping; head_d is what the output register shows next cycle
   always_comb begin
      flush = FLUSH_EN & new_blk;
      pop   = res_valid_o & res_ready_i & ~flush;
      wdata = {nonce, tag};
      if (flush) begin
         rd_d = wr_q;
         base = '0;
      end else begin
         rd_d = rd_q + PTR_W'(pop);
         base = fill_q - (PTR_W+1)'(pop);
      end
      // Space freed by a same-cycle pop is usable by the push
      do_push = push_req & (base != DEPTH_C);
      drop    = push_req & ~do_push;
      wr_d    = wr_q + PTR_W'(do_push);
      fill_d  = base + (PTR_W+1)'(do_push);
      head_d  = (base == '0) ? wdata : mem[rd_d];
   end

   // State, counters, FIFO pointers and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         blk_q       <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         fill_q      <= '0;
         res_valid_o <= 1'b0;
         res_nonce_o <= '0;
         res_block_o <= '0;
         exhausted_o <= 1'b0;
         overflow_o  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         blk_q       <= blk_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         fill_q      <= fill_d;
         exhausted_o <= exh_d;
         overflow_o  <= overflow_o | drop;
         res_valid_o <= (fill_d != '0);
         if (fill_d != '0) begin
            {res_nonce_o, res_block_o} <= head_d;
         end
      end
   end

   // Hit storage; contents are only read once written, so no reset needed
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_q] <= wdata;
      end
   end

endmodule

// File: tb/tb_lattice_result_collector.sv
// Self-checking bench for lattice_result_collector: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_lattice_result_collector;

   logic        clk;
   logic        rst;
   logic        valid, nb, succ, rdy;
   logic [0:0]  part;
   logic        res_valid, exh, ovf;
   logic [31:0] res_nonce;
   logic [3:0]  res_block;

   logic        v4, nb4, s4, rdy4;
   logic [0:0]  p4;
   logic        res_valid4, exh4, ovf4;
   logic [3:0]  res_nonce4;
   logic [3:0]  res_block4;

   int total = 0;
   int bad   = 0;

   lattice_result_collector #(.LOG2_NUM_CORES(1), .NONCE_BITS(32), .FIFO_DEPTH(4), .BLOCK_ID_BITS(4)) dut (
      .clk(clk), .rst(rst), .valid_i(valid), .new_block_i(nb), .success_i(succ),
      .partition_i(part), .res_valid_o(res_valid), .res_ready_i(rdy),
      .res_nonce_o(res_nonce), .res_block_o(res_block),
      .exhausted_o(exh), .overflow_o(ovf));

   lattice_result_collector #(.LOG2_NUM_CORES(1), .NONCE_BITS(4), .FIFO_DEPTH(4), .BLOCK_ID_BITS(4)) dut4 (
      .clk(clk), .rst(rst), .valid_i(v4), .new_block_i(nb4), .success_i(s4),
      .partition_i(p4), .res_valid_o(res_valid4), .res_ready_i(rdy4),
      .res_nonce_o(res_nonce4), .res_block_o(res_block4),
      .exhausted_o(exh4), .overflow_o(ovf4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (32-bit nonce, 1 partition bit) ----------
   typedef struct {
      logic [31:0] n;
      logic [3:0]  b;
   } hit_t;

   hit_t        q[$];
   int          m_blk;
   logic        m_scan;
   longint      m_idx;
   logic        m_exh, m_ovf, m_valid;
   logic [31:0] m_nonce;
   logic [3:0]  m_bk;
   localparam longint MAX_IDX = (longint'(1) << 31) - 1;

   task automatic model_reset();
      q.delete();
      m_blk = 0; m_scan = 1'b0; m_idx = 0;
      m_exh = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
      m_nonce = '0; m_bk = '0;
   endtask

   task automatic model_cycle(input logic v, input logic n, input logic s, input logic p, input logic r);
      bit   pop;
      bit   acc;
      hit_t h;
      pop = (q.size() != 0) && r;
      acc = v && (n || m_scan);
      if (acc && n) begin
         m_blk  = (m_blk + 1) % 16;
         m_idx  = 0;
         m_scan = 1'b1;
         m_exh  = 1'b0;
`ifdef STALE_FLUSH_EN
         q.delete();
         pop = 1'b0;
`endif
      end
      if (pop) void'(q.pop_front());
      if (acc && s) begin
         h.n = 32'(m_idx * 2 + longint'(p));
         h.b = 4'(m_blk);
         if (q.size() < 4) q.push_back(h);
         else m_ovf = 1'b1;
      end
      if (acc) begin
         if (m_idx == MAX_IDX) begin
            m_exh = 1'b1; m_scan = 1'b0; m_idx = 0;
         end else begin
            m_idx++;
         end
      end
      m_valid = (q.size() != 0);
      if (m_valid) begin
         m_nonce = q[0].n;
         m_bk    = q[0].b;
      end
   endtask

   // One clock on the main DUT; outputs are stable when this returns
   task automatic step(input logic v, input logic n, input logic s, input logic p, input logic r);
      valid = v; nb = n; succ = s; part = p; rdy = r;
      v4 = 1'b0; nb4 = 1'b0; s4 = 1'b0; rdy4 = 1'b0;
      @(posedge clk);
      model_cycle(v, n, s, p, r);
      #1;
   endtask

   // One clock on the small-nonce DUT, main DUT held idle
   task automatic step4(input logic v, input logic n, input logic s, input logic p, input logic r);
      v4 = v; nb4 = n; s4 = s; p4 = p; rdy4 = r;
      valid = 1'b0; nb = 1'b0; succ = 1'b0; rdy = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      valid = 1'b0; nb = 1'b0; succ = 1'b0; part = '0; rdy = 1'b0;
      v4 = 1'b0; nb4 = 1'b0; s4 = 1'b0; p4 = '0; rdy4 = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (res_valid !== 1'b0 || res_nonce !== 32'h0 || res_block !== 4'h0 || exh !== 1'b0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: got v=%b n=%h b=%h e=%b o=%b, want all 0", res_valid, res_nonce, res_block, exh, ovf);
      end
      total++;
      if (res_valid4 !== 1'b0 || exh4 !== 1'b0 || ovf4 !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs4: got v=%b e=%b o=%b, want 0", res_valid4, exh4, ovf4);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_first_hit();
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      total++;
      if (res_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_ignore: got valid=%b, want 0", res_valid);
      end
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      total++;
      if (res_valid !== 1'b1 || res_nonce !== 32'h1 || res_block !== 4'h1) begin
         bad++;
         $display("FAIL first_hit: got v=%b n=%h b=%h, want v=1 n=00000001 b=1", res_valid, res_nonce, res_block);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (res_valid !== 1'b0 || res_nonce !== 32'h1) begin
         bad++;
         $display("FAIL first_pop: got v=%b n=%h, want v=0 n held 00000001", res_valid, res_nonce);
      end
   endtask

   task automatic test_stall();
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (res_valid !== 1'b1 || res_nonce !== 32'hA || res_block !== 4'h2) begin
         bad++;
         $display("FAIL sixth_slice: got v=%b n=%h b=%h, want v=1 n=0000000a b=2", res_valid, res_nonce, res_block);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         total++;
         if (res_valid !== 1'b1 || res_nonce !== 32'hA || res_block !== 4'h2) begin
            bad++;
            $display("FAIL stall_hold[%0d]: got v=%b n=%h b=%h, want v=1 n=0000000a b=2", i, res_valid, res_nonce, res_block);
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (res_valid !== 1'b0) begin
         bad++;
         $display("FAIL stall_pop: got valid=%b, want 0", res_valid);
      end
   endtask

   task automatic test_overflow();
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      total++;
      if (ovf !== 1'b1 || ovf !== m_ovf || res_valid !== 1'b1) begin
         bad++;
         $display("FAIL overflow_flag: got ovf=%b valid=%b, want ovf=1 valid=1", ovf, res_valid);
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (res_valid !== m_valid || (m_valid && (res_nonce !== m_nonce || res_block !== m_bk))) begin
            bad++;
            $display("FAIL drain[%0d]: got v=%b n=%h b=%h, want v=%b n=%h b=%h", i, res_valid, res_nonce, res_block, m_valid, m_nonce, m_bk);
         end
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      total++;
      if (res_valid !== 1'b0 || q.size() != 0) begin
         bad++;
         $display("FAIL fifth_absent: got valid=%b, want 0", res_valid);
      end
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (res_valid !== m_valid || (m_valid && (res_nonce !== m_nonce || res_block !== m_bk))) begin
            bad++;
            $display("FAIL full_push_pop[%0d]: got v=%b n=%h b=%h, want v=%b n=%h b=%h", i, res_valid, res_nonce, res_block, m_valid, m_nonce, m_bk);
         end
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_exhaust();
      step4(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i < 7; i++) step4(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (exh4 !== 1'b0) begin
         bad++;
         $display("FAIL exhaust_early: got exhausted=%b after 7 slices, want 0", exh4);
      end
      step4(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (exh4 !== 1'b1 || res_valid4 !== 1'b1 || res_nonce4 !== 4'h1 || res_block4 !== 4'h1) begin
         bad++;
         $display("FAIL exhaust_set: got e=%b v=%b n=%h b=%h, want e=1 v=1 n=1 b=1", exh4, res_valid4, res_nonce4, res_block4);
      end
      step4(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step4(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (res_valid4 !== 1'b1 || res_nonce4 !== 4'hE || res_block4 !== 4'h1 || exh4 !== 1'b1) begin
         bad++;
         $display("FAIL exhaust_last_slice: got v=%b n=%h b=%h e=%b, want v=1 n=e b=1 e=1", res_valid4, res_nonce4, res_block4, exh4);
      end
      step4(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (res_valid4 !== 1'b0) begin
         bad++;
         $display("FAIL exhaust_ignored_hit: got valid=%b, want 0", res_valid4);
      end
      step4(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if (exh4 !== 1'b0 || res_valid4 !== 1'b1 || res_nonce4 !== 4'h0 || res_block4 !== 4'h2) begin
         bad++;
         $display("FAIL exhaust_new_block: got e=%b v=%b n=%h b=%h, want e=0 v=1 n=0 b=2", exh4, res_valid4, res_nonce4, res_block4);
      end
      step4(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_stale();
      logic [3:0] old_blk;
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      old_blk = 4'(m_blk);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef STALE_FLUSH_EN
      total++;
      if (res_valid !== 1'b0) begin
         bad++;
         $display("FAIL stale_flush: got valid=%b, want 0", res_valid);
      end
`else
      total++;
      if (res_valid !== 1'b1 || res_block !== old_blk) begin
         bad++;
         $display("FAIL stale_keep: got v=%b b=%h, want v=1 b=%h", res_valid, res_block, old_blk);
      end
`endif
      for (int i = 0; i < 3; i++) begin
         total++;
         if (res_valid !== m_valid || (m_valid && (res_nonce !== m_nonce || res_block !== m_bk))) begin
            bad++;
            $display("FAIL stale_drain[%0d]: got v=%b n=%h b=%h, want v=%b n=%h b=%h", i, res_valid, res_nonce, res_block, m_valid, m_nonce, m_bk);
         end
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 4),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         total++;
         if (res_valid !== m_valid || (m_valid && (res_nonce !== m_nonce || res_block !== m_bk)) ||
             exh !== m_exh || ovf !== m_ovf) begin
            bad++;
            $display("FAIL random[%0d]: got v=%b n=%h b=%h e=%b o=%b, want v=%b n=%h b=%h e=%b o=%b", i,
                     res_valid, res_nonce, res_block, exh, ovf, m_valid, m_nonce, m_bk, m_exh, m_ovf);
         end
      end
      repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (res_valid !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_valid: got valid=%b, want 1", res_valid);
      end
      #3 rst = 1'b0;
      #1;
      total++;
      if (res_valid !== 1'b0 || res_nonce !== 32'h0 || res_block !== 4'h0 || exh !== 1'b0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: got v=%b n=%h b=%h e=%b o=%b, want all 0", res_valid, res_nonce, res_block, exh, ovf);
      end
      model_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         total++;
         if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_empty[%0d]: got valid=%b, want 0", i, res_valid);
         end
      end
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if (res_valid !== 1'b1 || res_nonce !== 32'h0 || res_block !== 4'h1) begin
         bad++;
         $display("FAIL post_reset_block: got v=%b n=%h b=%h, want v=1 n=00000000 b=1", res_valid, res_nonce, res_block);
      end
   endtask

   initial begin
      test_reset();
      test_first_hit();
      test_stall();
      test_overflow();
      test_exhaust();
      test_stale();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
